// File: rtl/simon_host_ctrl.sv
// Host-side sequencer for a SIMON block-cipher core. It turns key and data valid/ready
// streams into newKey/newData requests and collects results into a small FIFO.
// Latency: accept to newData is 1 cycle. doneData to out_valid is 1 cycle when the FIFO has room.
// Backpressure: when the FIFO is full, readData is withheld, so the core holds doneData.
// The data FSM then stalls in D_BUSY and in_ready stays low.
// Ports:
//   clk, R                         clock and asynchronous active-high reset
//   key_valid/key_in/key_ready     key stream (word 0 in LSBs); takes priority over data
//   in_valid/in_data/in_mode/in_ready  block stream, in_mode 1 = encrypt
//   out_valid/out_data/out_ready   result stream, head of the output FIFO
//   newKey/key, newData/plain/enc_dec  requests and registered operands to the core
//   ldKey, ldData                  core acknowledges that it latched the operands
//   doneData/cipher/readData       core result and the host acknowledge

module simon_host_ctrl #(
    parameter int N    = 64,
    parameter int M    = 3,
    parameter int OBUF = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             key_valid,
    input  logic [M*N-1:0]   key_in,
    output logic             key_ready,
    input  logic             in_valid,
    input  logic [2*N-1:0]   in_data,
    input  logic             in_mode,
    output logic             in_ready,
    output logic             out_valid,
    output logic [2*N-1:0]   out_data,
    input  logic             out_ready,
    output logic             newData,
    output logic             newKey,
    output logic [2*N-1:0]   plain,
    output logic [M*N-1:0]   key,
    output logic             enc_dec,
    output logic             readData,
    input  logic             ldData,
    input  logic             ldKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   cipher
);

    localparam int AW = (OBUF > 1) ? $clog2(OBUF) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(OBUF);

    typedef enum logic [1:0] {K_IDLE, K_REQ, K_REL} k_state_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_REL, D_BUSY} d_state_t;
    typedef enum logic {RD_IDLE, RD_ACK} rd_state_t;

    k_state_t  k_state, k_next;
    d_state_t  d_state, d_next;
    rd_state_t rd_state, rd_next;

    logic            key_loaded;
    logic            key_acc, in_acc, key_done;
    logic            cap, pop, full;

    logic [2*N-1:0]  buf_mem [OBUF];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = buf_mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // One capture per doneData high period: leaving RD_IDLE blocks re-capture until doneData falls.
    assign cap       = (rd_state == RD_IDLE) & doneData & ~full;
    assign key_acc   = key_valid & key_ready;
    assign in_acc    = in_valid & in_ready;
    assign key_done  = (k_state == K_REL) & ~ldKey;

    always_comb begin
        k_next    = k_state;
        d_next    = d_state;
        rd_next   = rd_state;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        newKey    = 1'b0;
        newData   = 1'b0;
        readData  = 1'b0;

        // Key changes only while no block is in flight in the core.
        case (k_state)
            K_IDLE: begin
                key_ready = (d_state == D_IDLE);
                if (key_valid && (d_state == D_IDLE)) k_next = K_REQ;
            end
            K_REQ: begin
                newKey = 1'b1;
                if (ldKey) k_next = K_REL;
            end
            K_REL:   if (!ldKey) k_next = K_IDLE;
            default: k_next = K_IDLE;
        endcase

        // A pending key offer masks in_ready, which gives the key priority.
        case (d_state)
            D_IDLE: begin
                in_ready = key_loaded & (k_state == K_IDLE) & ~key_valid;
                if (in_valid && key_loaded && (k_state == K_IDLE) && !key_valid) d_next = D_REQ;
            end
            D_REQ: begin
                newData = 1'b1;
                if (ldData) d_next = D_REL;
            end
            D_REL:   if (!ldData) d_next = D_BUSY;
            D_BUSY:  if (cap) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase

        case (rd_state)
            RD_IDLE: if (cap) rd_next = RD_ACK;
            RD_ACK: begin
                readData = 1'b1;
                if (!doneData) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            k_state    <= K_IDLE;
            d_state    <= D_IDLE;
            rd_state   <= RD_IDLE;
            key_loaded <= 1'b0;
            key        <= '0;
            plain      <= '0;
            enc_dec    <= 1'b0;
        end else begin
            k_state  <= k_next;
            d_state  <= d_next;
            rd_state <= rd_next;
            if (key_done) key_loaded <= 1'b1;
            if (key_acc)  key <= key_in;
            if (in_acc) begin
                plain   <= in_data;
                enc_dec <= in_mode;
            end
        end
    end

    // Output FIFO. When it is full, cap is already low, so a simultaneous pop
    // frees the slot and the held doneData is captured on the following cycle.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OBUF; i++) buf_mem[i] <= '0;
        end else begin
            if (cap) begin
                buf_mem[wr_ptr] <= cipher;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({cap, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_host_ctrl.sv
// Bench for simon_host_ctrl. A behavioural SIMON128/192 core answers the request handshakes.
// Expected results come from a reference cipher function and are held in an in-order queue.

module tb_simon_host_ctrl;

    localparam int N = 64;
    localparam int M = 3;

    logic             clk = 1'b0;
    logic             R;
    logic             key_valid, in_valid, in_mode, out_ready;
    logic [M*N-1:0]   key_in;
    logic [2*N-1:0]   in_data;
    logic             key_ready, in_ready, out_valid;
    logic [2*N-1:0]   out_data;
    logic             newData, newKey, enc_dec, readData;
    logic [2*N-1:0]   plain;
    logic [M*N-1:0]   key;
    logic             ldData, ldKey, doneData;
    logic [2*N-1:0]   cipher;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    int n_req  = 0;
    int ld_hold = 1;
    logic [2*N-1:0] last_out;
    logic [M*N-1:0] cur_key;
    logic [2*N-1:0] exp_q [$];

    localparam logic [M*N-1:0] VKEY = 192'h17161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [2*N-1:0] VPT  = 128'h206572656874206e6568772065626972;
    localparam logic [2*N-1:0] VCT  = 128'hc4ac61effcdc0d4f6c9c8d6e2597b85b;

    always #5 clk = ~clk;

    simon_host_ctrl #(.N(N), .M(M), .OBUF(2)) dut (
        .clk(clk), .R(R),
        .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .newData(newData), .newKey(newKey), .plain(plain), .key(key), .enc_dec(enc_dec),
        .readData(readData), .ldData(ldData), .ldKey(ldKey), .doneData(doneData), .cipher(cipher)
    );

    // ---------------- reference SIMON128/192 ----------------
    function automatic logic [63:0] rol(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [63:0] fr(input logic [63:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [127:0] simon_ref(input logic [191:0] k, input logic [127:0] b,
                                               input logic enc);
        logic [63:0] rk [0:68];
        logic [61:0] z;
        logic [63:0] x, y, t;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        rk[0] = k[63:0];
        rk[1] = k[127:64];
        rk[2] = k[191:128];
        for (int i = 3; i < 69; i++) begin
            t = rol(rk[i-1], 61);
            t = t ^ rol(t, 63);
            rk[i] = ~rk[i-3] ^ t ^ {63'b0, z[61 - ((i - 3) % 62)]} ^ 64'd3;
        end
        x = b[127:64];
        y = b[63:0];
        if (enc) begin
            for (int i = 0; i < 69; i++) begin
                t = x;
                x = y ^ fr(x) ^ rk[i];
                y = t;
            end
        end else begin
            for (int i = 68; i >= 0; i--) begin
                t = y;
                y = x ^ fr(t) ^ rk[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural core ----------------
    initial begin
        int cst;
        int cnt;
        logic [M*N-1:0] core_key;
        logic [2*N-1:0] res;
        cst = 0; cnt = 0; core_key = '0; res = '0;
        ldKey = 1'b0; ldData = 1'b0; doneData = 1'b0;
        cipher = {$urandom(), $urandom(), $urandom(), $urandom()};
        forever begin
            @(posedge clk); #1;
            if (R) begin
                ldKey = 1'b0; ldData = 1'b0; doneData = 1'b0; cst = 0;
            end else begin
                if (ldKey) ldKey = 1'b0;
                else if (newKey) begin
                    core_key = key;
                    ldKey = 1'b1;
                end
                case (cst)
                    0: if (newData) begin
                        res = simon_ref(core_key, plain, enc_dec);
                        ldData = 1'b1;
                        n_req++;
                        cnt = ld_hold;
                        cst = 1;
                    end
                    1: begin
                        chk("newdata_after_ld", newData, 0);
                        if (cnt > 1) cnt--;
                        else begin
                            ldData = 1'b0;
                            cnt = $urandom_range(2, 6);
                            cst = 2;
                        end
                    end
                    2: if (cnt > 1) cnt--;
                       else begin
                           doneData = 1'b1;
                           cipher = res;
                           cst = 3;
                       end
                    default: if (readData) begin
                        doneData = 1'b0;
                        cipher = {$urandom(), $urandom(), $urandom(), $urandom()};
                        cst = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- output scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!R && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_spurious", out_valid, 0);
                else chk("out_data", out_data, exp_q.pop_front());
                last_out = out_data;
                n_out++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_key(input logic [M*N-1:0] k);
        int n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_in = k;
        #1;
        while (!key_ready && n < 500) begin
            @(negedge clk); #1; n++;
        end
        chk("key_accept", key_ready, 1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        cur_key = k;
    endtask

    task automatic send_block(input logic [2*N-1:0] b, input logic mode);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        in_mode = mode;
        #1;
        while (!in_ready && n < 500) begin
            @(negedge clk); #1; n++;
        end
        chk("block_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(simon_ref(cur_key, b, mode));
        chk("accept_to_newdata", newData, 1);
    endtask

    task automatic wait_out(input int target, input string tag);
        int n = 0;
        while (n_out < target && n < 2000) begin
            @(negedge clk); n++;
        end
        chk(tag, n_out, target);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int base, req0, n;
        R = 1'b1; key_valid = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        key_in = '0; in_data = '0; cur_key = '0; last_out = '0;

        // 1: reset values
        repeat (3) @(posedge clk);
        @(negedge clk); R = 1'b0; #1;
        chk("rst_newData", newData, 0);
        chk("rst_newKey", newKey, 0);
        chk("rst_readData", readData, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_plain", plain, 0);
        chk("rst_key", key, 0);
        chk("rst_enc_dec", enc_dec, 0);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        in_valid = 1'b1;
        repeat (3) begin @(negedge clk); #1; chk("no_key_in_ready", in_ready, 0); end
        in_valid = 1'b0;

        // 2: known-answer encrypt
        send_key(VKEY);
        chk("key_reg", key, VKEY);
        base = n_out; req0 = n_req;
        send_block(VPT, 1'b1);
        chk("plain_reg", plain, VPT);
        n = 0;
        @(negedge clk);
        while (!doneData && n < 200) begin @(negedge clk); n++; end
        chk("done_seen", doneData, 1);
        @(posedge clk); #1;
        chk("done_to_out_valid", out_valid, 1);
        chk("done_to_readData", readData, 1);
        wait_out(base + 1, "kat_enc_count");
        chk("kat_enc_value", last_out, VCT);
        repeat (10) @(negedge clk);
        chk("kat_single_out", n_out, base + 1);
        chk("kat_one_req", n_req, req0 + 1);

        // 3: five back-to-back random blocks under a random key
        send_key({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        base = n_out; req0 = n_req;
        for (int i = 0; i < 5; i++) send_block(rnd128(), 1'($urandom_range(0, 1)));
        wait_out(base + 5, "b2b_count");
        chk("b2b_one_req_each", n_req, req0 + 5);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // 4: downstream stalled, FIFO fills, readData withheld
        @(posedge clk); #1; out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < 3; i++) send_block(rnd128(), 1'($urandom_range(0, 1)));
        n = 0;
        @(negedge clk);
        while (!doneData && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("stall_done_held", doneData, 1);
        chk("stall_no_readData", readData, 0);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_head", out_data, exp_q[0]);
        chk("stall_no_pop", n_out, base);
        @(posedge clk); #1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) send_block(rnd128(), 1'($urandom_range(0, 1)));
        wait_out(base + 5, "stall_count");
        chk("stall_queue_empty", exp_q.size(), 0);

        // 5: known-answer decrypt
        send_key(VKEY);
        base = n_out;
        send_block(VCT, 1'b0);
        wait_out(base + 1, "kat_dec_count");
        chk("kat_dec_value", last_out, VPT);

        // 6: reset while the block is in D_REL
        ld_hold = 3;
        base = n_out;
        send_block(rnd128(), 1'b1);
        n = 0;
        @(negedge clk);
        while (!(ldData && !newData) && n < 50) begin @(negedge clk); n++; end
        chk("rel_reached", ldData, 1);
        #1; R = 1'b1; #1;
        chk("mid_rst_newData", newData, 0);
        chk("mid_rst_readData", readData, 0);
        @(posedge clk); #1;
        chk("mid_rst_edge_newData", newData, 0);
        chk("mid_rst_edge_readData", readData, 0);
        exp_q.delete();
        @(negedge clk); R = 1'b0; ld_hold = 1;
        in_valid = 1'b1; in_data = rnd128(); in_mode = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("post_rst_in_ready", in_ready, 0);
            chk("post_rst_newData", newData, 0);
        end
        in_valid = 1'b0;
        chk("post_rst_no_out", n_out, base);
        send_key({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        send_block(rnd128(), 1'b0);
        wait_out(base + 1, "post_rst_count");
        repeat (10) @(negedge clk);
        chk("post_rst_single_out", n_out, base + 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
